// File: rtl/detect_58_pkg.sv
// Shared constants for the "58" serial pattern detector and its channel scheduler.
// DET_SEQ is sent first bit first, i.e. MSB first.
package detect_58_pkg;

    localparam int unsigned DET_SW = 4;
    localparam logic [DET_SW-1:0] DET_IDLE = 4'd0;
    localparam logic [DET_SW-1:0] DET_ACCEPT = 4'd8;
    localparam int unsigned DET_SEQ_LEN = 8;
    localparam logic [DET_SEQ_LEN-1:0] DET_SEQ = 8'b0101_1000;

    // Bit k of the detected sequence, k = 0 being the first bit on the wire.
    function automatic logic det_seq_bit(input int unsigned k);
        return DET_SEQ[3'(DET_SEQ_LEN - 1 - k)];
    endfunction

endpackage

// File: rtl/detect_58_next.sv
// Next-state lookup for the overlapping "58" (0101_1000) detector.
// State n means the last n bits matched the first n bits of DET_SEQ.
module detect_58_next
    import detect_58_pkg::*;
(
    input  logic              in_bit,
    input  logic [DET_SW-1:0] st,
    output logic [DET_SW-1:0] ns
);

    always_comb begin
        ns = DET_IDLE;
        if (st < DET_ACCEPT && in_bit == det_seq_bit(32'(st))) begin
            ns = st + 4'd1;
        end else begin
            // Mismatch: fall back to the longest sequence prefix that is still a suffix.
            case (st)
                4'd1:    ns = 4'd1;
                4'd3:    ns = 4'd1;
                4'd4:    ns = 4'd3;
                4'd6:    ns = 4'd2;
                4'd7:    ns = 4'd2;
                4'd8:    ns = in_bit ? 4'd2 : 4'd1;
                default: ns = DET_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/detect_58_sched_rr_arb_n.sv
// Round-robin arbiter: the first requester at or after ptr (mod NCH) is granted.
module rr_arb_n #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] gnt,
    output logic [CHW-1:0] gnt_idx
);

    logic           found;
    logic [CHW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            idx = CHW'((32'(ptr) + 32'(k)) % NCH);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/detect_58_sched.sv
// Shares one detect_58_next lookup across NCH serial channels, one granted bit per cycle.
// Keeps per-channel detector state and a saturating hit counter.
module detect_58_sched
    import detect_58_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 2,
    parameter int unsigned CW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [NCH-1:0] in_valid,
    input  logic [NCH-1:0] in_bit,
    output logic [NCH-1:0] in_ready,
    input  logic [NCH-1:0] clr,
    output logic           det_valid,
    output logic [CHW-1:0] det_ch,
    input  logic [CHW-1:0] rd_ch,
    output logic [CW-1:0]  rd_cnt
);

    localparam logic [CW-1:0] CntMax = '1;

    logic [DET_SW-1:0] st_q      [NCH];
    logic [DET_SW-1:0] st_d      [NCH];
    logic [CW-1:0]     hit_cnt_q [NCH];
    logic [CW-1:0]     hit_cnt_d [NCH];
    logic [CHW-1:0]    ptr_q, ptr_d;
    logic              det_valid_q, det_valid_d;
    logic [CHW-1:0]    det_ch_q, det_ch_d;

    logic [NCH-1:0]    req, gnt;
    logic [CHW-1:0]    gnt_idx;
    logic [DET_SW-1:0] ns;

    // Holding req low in reset keeps in_ready low while rst is asserted.
    assign req = {NCH{en & ~rst}} & in_valid & ~clr;

    rr_arb_n #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    detect_58_next u_next (
        .in_bit (in_bit[gnt_idx]),
        .st     (st_q[gnt_idx]),
        .ns     (ns)
    );

    assign in_ready  = gnt;
    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign rd_cnt    = (32'(rd_ch) < NCH) ? hit_cnt_q[rd_ch] : '0;

    always_comb begin
        st_d        = st_q;
        hit_cnt_d   = hit_cnt_q;
        ptr_d       = ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        if (|gnt) begin
            st_d[gnt_idx] = ns;
            ptr_d         = CHW'((32'(gnt_idx) + 32'd1) % NCH);
            if (ns == DET_ACCEPT) begin
                det_valid_d = 1'b1;
                det_ch_d    = gnt_idx;
                if (hit_cnt_q[gnt_idx] != CntMax) begin
                    hit_cnt_d[gnt_idx] = hit_cnt_q[gnt_idx] + 1'b1;
                end
            end
        end
        for (int i = 0; i < int'(NCH); i++) begin
            if (clr[i]) begin
                st_d[i]      = DET_IDLE;
                hit_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NCH); i++) begin
                st_q[i]      <= DET_IDLE;
                hit_cnt_q[i] <= '0;
            end
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            st_q        <= st_d;
            hit_cnt_q   <= hit_cnt_d;
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
        end
    end

endmodule

// File: tb/tb_detect_58_sched.sv
// Directed bench for detect_58_sched; detection pulses are checked against a scoreboard queue.
module tb_detect_58_sched;

    localparam logic [7:0] SEQ = 8'b0101_1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] in_valid = '0;
    logic [3:0] in_bit = '0;
    logic [3:0] in_ready;
    logic [3:0] clr = '0;
    logic       det_valid;
    logic [1:0] det_ch;
    logic [1:0] rd_ch = '0;
    logic [1:0] rd_cnt;

    int n_tests = 0;
    int n_fail = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    detect_58_sched #(
        .NCH (4),
        .CHW (2),
        .CW  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .clr       (clr),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .rd_ch     (rd_ch),
        .rd_cnt    (rd_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every detection pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (det_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL det_unexpected: got pulse ch %0d expected none at %0t",
                         det_ch, $time);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (det_ch != e) begin
                    n_fail++;
                    $display("FAIL det_ch: got %0d expected %0d at %0t", det_ch, e, $time);
                end
            end
        end
    end

    // One cycle of stimulus; exp_det >= 0 means that channel's bit completes DET_SEQ.
    task automatic drive(input logic e, input logic [3:0] v, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] exp_rdy, input int exp_det);
        @(negedge clk);
        en = e; in_valid = v; in_bit = b; clr = c;
        if (exp_det >= 0) exp_q.push_back(2'(exp_det));
        #1 check("in_ready", int'(in_ready), int'(exp_rdy));
    endtask

    task automatic rd_chk(input logic [1:0] ch, input int exp);
        @(negedge clk);
        in_valid = '0; clr = '0; rd_ch = ch;
        #1 check($sformatf("rd_cnt[%0d]", ch), int'(rd_cnt), exp);
    endtask

    task automatic clr_all(input logic [3:0] c);
        drive(1'b1, 4'b0000, 4'b0000, c, 4'b0000, -1);
    endtask

    initial begin
        int idx[4];
        int g;
        logic [3:0] b;

        // 1: reset values, then reset asserted mid-stream on ch0
        repeat (2) @(negedge clk);
        en = 1'b1; in_valid = 4'b1111;
        #1 check("rst_in_ready", int'(in_ready), 0);
        check("rst_det_valid", int'(det_valid), 0);
        @(negedge clk);
        rst = 1'b0; in_valid = '0;
        for (int k = 0; k < 3; k++) drive(1'b1, 4'b0001, {3'b000, SEQ[7-k]}, 4'b0000, 4'b0001, -1);
        @(negedge clk);
        rst = 1'b1; in_valid = 4'b0001;
        #1 check("rst_mid_in_ready", int'(in_ready), 0);
        check("rst_mid_det_valid", int'(det_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; in_valid = '0;
        for (int c = 0; c < 4; c++) rd_chk(2'(c), 0);
        // Tail 1,1,0,0,0 completes DET_SEQ only if ch0 kept state 3 across reset
        for (int k = 3; k < 8; k++) drive(1'b1, 4'b0001, {3'b000, SEQ[7-k]}, 4'b0000, 4'b0001, -1);

        // 2: ch2 alone, back-to-back sequence
        clr_all(4'b1111);
        for (int k = 0; k < 8; k++)
            drive(1'b1, 4'b0100, {1'b0, SEQ[7-k], 2'b00}, 4'b0000, 4'b0100, (k == 7) ? 2 : -1);
        rd_chk(2'd2, 1);

        // 3: all channels continuously; one ch3 grant first to bring ptr to 0
        drive(1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, -1);
        clr_all(4'b1111);
        idx = '{0, 0, 0, 0};
        for (int j = 0; j < 32; j++) begin
            for (int c = 0; c < 4; c++) b[c] = SEQ[7 - (idx[c] % 8)];
            g = j % 4;
            drive(1'b1, 4'b1111, b, 4'b0000, 4'(1 << g), (idx[g] == 7) ? g : -1);
            idx[g]++;
        end
        for (int c = 0; c < 4; c++) rd_chk(2'(c), 1);

        // 4: clr on ch1 while it presents its final bit, ptr=1, ch2 also requesting
        clr_all(4'b1111);
        for (int k = 0; k < 7; k++)
            drive(1'b1, 4'b0010, {2'b00, SEQ[7-k], 1'b0}, 4'b0000, 4'b0010, -1);
        drive(1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, -1);
        drive(1'b1, 4'b0110, 4'b0000, 4'b0010, 4'b0100, -1);
        rd_chk(2'd1, 0);
        // A final 0 would accept from state 7; from idle it must not
        drive(1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, -1);

        // 5: ch3 completes DET_SEQ five times (overlap-free restart), CW=2 saturates at 3
        clr_all(4'b1111);
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 8; k++)
                drive(1'b1, 4'b1000, {SEQ[7-k], 3'b000}, 4'b0000, 4'b1000, (k == 7) ? 3 : -1);
        rd_chk(2'd3, 3);

        // 6: enable stall; ch3 keeps count 3, ch1 left at state 1, ptr=2
        clr_all(4'b0111);
        drive(1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, -1);
        for (int k = 0; k < 10; k++) drive(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, -1);
        rd_chk(2'd3, 3);
        rd_chk(2'd1, 0);
        drive(1'b1, 4'b1111, 4'b0010, 4'b0000, 4'b0100, -1);
        drive(1'b1, 4'b1111, 4'b0010, 4'b0000, 4'b1000, -1);
        drive(1'b1, 4'b1111, 4'b0010, 4'b0000, 4'b0001, -1);
        drive(1'b1, 4'b1111, 4'b0010, 4'b0000, 4'b0010, -1);
        // ch1 now at state 2 only if the stall left it at 1: remaining 0,1,1,0,0,0
        for (int k = 2; k < 8; k++)
            drive(1'b1, 4'b0010, {2'b00, SEQ[7-k], 1'b0}, 4'b0000, 4'b0010, (k == 7) ? 1 : -1);
        rd_chk(2'd1, 1);
        rd_chk(2'd3, 3);

        repeat (3) @(negedge clk);
        check("det_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
